// File: rtl/ysyx_25040111_bpu_pkg.sv
// ysyx_25040111_bpu_pkg
//   Shared definitions for the branch prediction unit and its helpers.
//   - ctr_e: 2-bit direction counter encodings (strong/weak not-taken/taken)
//   - default table geometry, used by the BPU and by the EXU checker so
//     both sides agree on the index/tag split
package ysyx_25040111_bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int BPU_ENTRIES_DEF  = 64;
  localparam int BPU_TAG_W_DEF    = 8;
  localparam int BPU_HIST_LEN_DEF = 6;
  localparam int BPU_CNT_W_DEF    = 32;

endpackage

// File: rtl/ysyx_25040111_satcnt2.sv
// ysyx_25040111_satcnt2
//   Next-state logic of a 2-bit saturating direction counter.
//   Ports:
//     ctr      in  2  current counter value
//     taken    in  1  resolved outcome
//     ctr_next out 2  counter after training (clamped at 2'b11 / 2'b00)
module ysyx_25040111_satcnt2
  import ysyx_25040111_bpu_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/ysyx_25040111_bpu.sv
// ysyx_25040111_bpu
//   Branch prediction unit: tagged target buffer with 2-bit direction
//   counters and optional gshare indexing.  Lookup is combinational; the
//   table is trained from resolved EXU branches at the next clock edge.
//   Ports:
//     clock, reset_n            core clock, synchronous active-low reset
//     lk_pc, lk_valid           fetch lookup request
//     pred_taken, pred_target   prediction (target meaningful when taken)
//     pred_ghr                  history snapshot used by this lookup
//     upd_*                     resolved branch training interface
//     flush_hist                clear global history
//     stat_lookups/mispreds     free-running performance counters
module ysyx_25040111_bpu
  import ysyx_25040111_bpu_pkg::*;
#(
  parameter int ENTRIES  = BPU_ENTRIES_DEF,
  parameter int TAG_W    = BPU_TAG_W_DEF,
  parameter int HIST_LEN = BPU_HIST_LEN_DEF,
  parameter int GSHARE   = 1,
  parameter int CNT_W    = BPU_CNT_W_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [31:0]         lk_pc,
  input  logic                lk_valid,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [HIST_LEN-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [HIST_LEN-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                upd_mispred,
  input  logic                flush_hist,
  output logic [CNT_W-1:0]    stat_lookups,
  output logic [CNT_W-1:0]    stat_mispreds
);

  localparam int IDX = $clog2(ENTRIES);

  logic              vld_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q [ENTRIES];
  logic [31:0]       tgt_q [ENTRIES];
  logic [1:0]        ctr_q [ENTRIES];
  logic [HIST_LEN-1:0] ghr_q;

  logic [IDX-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic [1:0]       upd_ctr_sat, upd_ctr_new;

  // History is zero-extended to the index width before hashing.
  always_comb begin
    lk_idx  = lk_pc[IDX+1:2];
    upd_idx = upd_pc[IDX+1:2];
    if (GSHARE != 0) begin
      lk_idx  = lk_idx ^ IDX'(ghr_q);
      upd_idx = upd_idx ^ IDX'(upd_ghr);
    end
  end

  assign lk_tag  = lk_pc[IDX+TAG_W+1:IDX+2];
  assign upd_tag = upd_pc[IDX+TAG_W+1:IDX+2];

  assign lk_hit      = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_valid && lk_hit && ctr_q[lk_idx][1];
  assign pred_target = tgt_q[lk_idx];
  assign pred_ghr    = ghr_q;

  assign upd_hit = vld_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  ysyx_25040111_satcnt2 u_satcnt (
    .ctr      (ctr_q[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (upd_ctr_sat)
  );

  // A fresh allocation starts weak in the observed direction.
  always_comb begin
    if (upd_hit)        upd_ctr_new = upd_ctr_sat;
    else if (upd_taken) upd_ctr_new = WT;
    else                upd_ctr_new = WNT;
  end

  // Whole table lives in flops so one reset cycle clears every entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= WNT;
      end
      ghr_q         <= '0;
      stat_lookups  <= '0;
      stat_mispreds <= '0;
    end else begin
      if (lk_valid)
        stat_lookups <= stat_lookups + CNT_W'(1);
      if (upd_valid && upd_mispred)
        stat_mispreds <= stat_mispreds + CNT_W'(1);

      // Flush wins over the shift; the truncating cast drops the oldest bit.
      if (flush_hist)
        ghr_q <= '0;
      else if (upd_valid)
        ghr_q <= HIST_LEN'({ghr_q, upd_taken});

      if (upd_valid) begin
        vld_q[upd_idx] <= 1'b1;
        tag_q[upd_idx] <= upd_tag;
        ctr_q[upd_idx] <= upd_ctr_new;
        if (!upd_hit || upd_taken)
          tgt_q[upd_idx] <= upd_target;
      end
    end
  end

  // Low PC bits and bits above the tag do not participate in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc, upd_pc};

endmodule

// File: doc/ysyx_25040111_bpu.md
Name: ysyx_25040111_bpu

Overview:
- Parametrised branch prediction unit for the ysyx_25040111 core.
- Looks up the fetch PC in the IFU each cycle and returns a predicted direction and target. It is trained non-speculatively by resolved branch outcomes from the EXU.
- Successor to the combinational B-type decode. It adds stateful direction prediction: 2-bit saturating counters, a tagged target buffer, optional gshare history, and performance counters.

Parameters:
- ENTRIES, 64, table depth; power of two, 4..1024.
- TAG_W, 8, PC tag bits stored per entry.
- HIST_LEN, 6, global history length; must be ≤ log2(ENTRIES).
- GSHARE, 1, 1 = index is PC index XOR history; 0 = PC index only (history still tracked).
- CNT_W, 32, performance counter width.

Ports:
- clock  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- lk_pc  in  32  fetch PC to predict
- lk_valid  in  1  lookup request this cycle
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted target; valid only when pred_taken=1
- pred_ghr  out  HIST_LEN  history snapshot used for the lookup; IFU carries it down the pipe
- upd_valid  in  1  resolved conditional branch from EXU
- upd_pc  in  32  branch PC
- upd_ghr  in  HIST_LEN  pred_ghr that travelled with this branch
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual target (pc+imm)
- upd_mispred  in  1  EXU detected a direction or target mismatch
- flush_hist  in  1  clear global history (fence.i / redirect from trap)
- stat_lookups  out  CNT_W  count of lk_valid cycles
- stat_mispreds  out  CNT_W  count of upd_valid && upd_mispred

Behaviour:
- Index and tag
  - IDX = log2(ENTRIES).
  - Lookup index = lk_pc[IDX+1:2], XOR {zero-pad, ghr} when GSHARE=1.
  - Update index is the same function of upd_pc and upd_ghr.
  - Tag = pc[IDX+TAG_W+1:IDX+2].
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Lookup is combinational, zero latency.
  - hit = valid && tag match.
  - pred_taken = lk_valid && hit && ctr[1].
  - pred_target = entry target.
  - pred_ghr = current ghr.
- Update takes effect at the next clock edge when upd_valid=1.
  - Hit: ctr saturating +1 if taken, −1 if not (clamp 2'b11 / 2'b00). Target overwritten when upd_taken=1.
  - Miss: allocate/replace. valid=1, tag written, target=upd_target, ctr = upd_taken ? 2'b10 : 2'b01.
- History: on upd_valid, ghr <= {ghr[HIST_LEN-2:0], upd_taken}. It is committed non-speculatively.
- flush_hist: ghr <= 0. It has priority over a same-cycle history shift; the table update still proceeds.
- Same-cycle lookup and update to the same entry: the lookup sees the pre-update value. There is no bypass.
- Performance counters: stat_lookups and stat_mispreds are free-running, increment by 1, and wrap to 0 at 2^CNT_W.
- Reset (reset_n=0 at a clock edge):
  - All valid=0, all ctr=2'b01, ghr=0, both stat counters=0.
  - pred_taken=0 while the table is invalid. pred_target is don't-care but is driven 0 from a cleared table.
  - Reset asserted mid-update discards that update.
- Non-branch and non-valid cycles leave all state unchanged.

Decomposition:
- Shared package/header (ysyx_25040111_inc.vh):
  - BPU counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Default ENTRIES/HIST_LEN macros.
  - The index-hash macro, reused by the EXU checker.
- Sub-module ysyx_25040111_satcnt2: 2-bit saturating counter next-state (inputs ctr, taken; output ctr_next). It is instantiated in the update path only.
- Table storage is flop arrays inside the BPU. Synthesis must not infer SRAM, because of the single-cycle reset requirement.

Test Plan:
- Reset then lk_pc=0x80000000, lk_valid=1 → pred_taken=0; stat_lookups increments to 1 on the next edge.
- Train PC 0x80000010 taken, target 0x80000040, twice (GSHARE=0) → lookup gives pred_taken=1, pred_target=0x80000040, ctr=2'b11. A further taken update keeps ctr=2'b11 (saturation).
- From ctr=2'b11, two not-taken updates → pred_taken=0; a third → ctr=2'b00 and stays there.
- Alias: PC 0x80000010 and 0x80000010+4*ENTRIES differ in tag. Training the second replaces the first → lookup of the first misses (pred_taken=0).
- GSHARE=1, HIST_LEN=6, taken/not-taken alternating at one PC for 20 updates, looking up with the current ghr → prediction correct ≥90% after warm-up. stat_mispreds equals the count of upd_mispred pulses. flush_hist then gives pred_ghr=0.
- Same-cycle update and lookup on one entry → old ctr observed. Asserting reset_n=0 in the cycle of an update → table cleared and the update is not applied.
